// File: rtl/seg7_defs.sv
// Shared seven-segment definitions: active-low glyphs {g,f,e,d,c,b,a},
// idle digit-enable pattern and BCD digit width.
package seg7_defs;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_IDLE = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-seven-segment decoder, active-low outputs.
// Codes above 9, or an asserted blank flag, produce an unlit digit.
module seg7_decode
  import seg7_defs::*;
(
  input  bcd_digit_t  digit_i,
  input  logic        blank_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives seg_o and no latch is inferred.
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_tick_display.sv
// 4-digit up/down BCD counter advanced on rising edges of cnt_en, with a
// multiplexed common-anode display driver. LEAD_ZERO_BLANK_EN blanks leading zeros.
module bcd_tick_display
  import seg7_defs::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int SCAN_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_en,
  input  logic                 up_dn,
  input  logic                 pause,
  output logic [4*BCD_W-1:0]   bcd,
  output logic                 wrap,
  output logic [3:0]           an,
  output logic [6:0]           seg
);

  logic                cnt_en_q;
  logic                tick;
  logic [4*BCD_W-1:0]  bcd_q, bcd_d;
  logic                wrap_q, wrap_d;
  logic [SCAN_W-1:0]   div_q;
  logic [1:0]          sel_q;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  bcd_digit_t          cur_digit;
  bcd_digit_t          step_digit;
  logic                step_carry;
  logic                blank;

  assign tick = cnt_en & ~cnt_en_q;

  // Ripple a carry (up) or borrow (down) through the digits; a carry out of
  // d3 means the whole count wrapped.
  always_comb begin
    bcd_d      = bcd_q;
    step_carry = 1'b1;
    step_digit = '0;
    for (int i = 0; i < 4; i++) begin
      step_digit = bcd_q[i*BCD_W +: BCD_W];
      if (step_carry) begin
        if (up_dn) begin
          if (step_digit == 4'd9) begin
            bcd_d[i*BCD_W +: BCD_W] = 4'd0;
          end else begin
            bcd_d[i*BCD_W +: BCD_W] = step_digit + 4'd1;
            step_carry = 1'b0;
          end
        end else begin
          if (step_digit == 4'd0) begin
            bcd_d[i*BCD_W +: BCD_W] = 4'd9;
          end else begin
            bcd_d[i*BCD_W +: BCD_W] = step_digit - 4'd1;
            step_carry = 1'b0;
          end
        end
      end
    end
    wrap_d = step_carry;
  end

  assign cur_digit = bcd_q[sel_q*BCD_W +: BCD_W];

`ifdef LEAD_ZERO_BLANK_EN
  // Shifting out the lower digits leaves this digit and all higher ones.
  assign blank = (sel_q != 2'd0) && ((bcd_q >> (sel_q * BCD_W)) == '0);
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  assign an_d = AN_IDLE & ~(4'b0001 << sel_q);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      cnt_en_q <= 1'b1;  // suppress a false tick if cnt_en is high at release
      bcd_q    <= '0;
      wrap_q   <= 1'b0;
      div_q    <= '0;
      sel_q    <= 2'd0;
      an_q     <= 4'b1110;
      seg_q    <= SEG_0;
    end else begin
      cnt_en_q <= cnt_en;
      if (tick && !pause) begin
        bcd_q  <= bcd_d;
        wrap_q <= wrap_d;
      end else begin
        wrap_q <= 1'b0;
      end
      if (div_q == SCAN_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        sel_q <= sel_q + 2'd1;
      end else begin
        div_q <= div_q + SCAN_W'(1);
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_tick_display.sv
// Self-checking bench for bcd_tick_display: randomized tick stimulus checked
// against an integer counter model and a glyph table.
module tb_bcd_tick_display;

  localparam int SCAN_DIV = 4;
  localparam int SCAN_W   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_en;
  logic        up_dn;
  logic        pause;
  logic [15:0] bcd;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;

  int vectors    = 0;
  int miscompares = 0;
  int model      = 0;

  bcd_tick_display #(.SCAN_DIV(SCAN_DIV), .SCAN_W(SCAN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_en (cnt_en),
    .up_dn  (up_dn),
    .pause  (pause),
    .bcd    (bcd),
    .wrap   (wrap),
    .an     (an),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input int v);
    int p10;
    p10 = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
`ifdef LEAD_ZERO_BLANK_EN
    if (idx > 0 && v < p10) return 7'h7F;
`endif
    return glyph((v / p10) % 10);
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    cnt_en = 1'b1;
    up_dn  = 1'b1;
    pause  = 1'b0;
    step();
    rst_n  = 1'b1;
    model  = 0;
  endtask

  // One cnt_en low phase followed by a rising edge; up_dn is driven to the
  // opposite value until the edge cycle itself.
  task automatic apply_tick(input bit up, input bit pz, input int low_len);
    int  prev;
    bit  exp_wrap;
    cnt_en = 1'b0;
    up_dn  = ~up;
    for (int i = 0; i < low_len; i++) begin
      pause = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if (bcd !== to_bcd(model) || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL low_phase: bcd=%h wrap=%b, want bcd=%h wrap=0", bcd, wrap, to_bcd(model));
      end
    end
    cnt_en = 1'b1;
    up_dn  = up;
    pause  = pz;
    step();
    prev     = model;
    exp_wrap = 1'b0;
    if (!pz) begin
      if (up) begin
        model    = (model + 1) % 10000;
        exp_wrap = (prev == 9999);
      end else begin
        model    = (model + 9999) % 10000;
        exp_wrap = (prev == 0);
      end
    end
    vectors++;
    if (bcd !== to_bcd(model) || wrap !== exp_wrap) begin
      miscompares++;
      $display("FAIL tick(up=%0b pause=%0b from %0d): bcd=%h wrap=%b, want bcd=%h wrap=%b",
               up, pz, prev, bcd, wrap, to_bcd(model), exp_wrap);
    end
    pause = 1'($urandom_range(0, 1));
    up_dn = 1'($urandom_range(0, 1));
    step();
    vectors++;
    if (bcd !== to_bcd(model) || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL post_tick: bcd=%h wrap=%b, want bcd=%h wrap=0", bcd, wrap, to_bcd(model));
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bcd !== 16'h0000 || wrap !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_state: bcd=%h wrap=%b an=%b seg=%b, want 0000 0 1110 1000000",
               bcd, wrap, an, seg);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (bcd !== 16'h0000 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL no_false_tick[%0d]: bcd=%h wrap=%b, want 0000 0", i, bcd, wrap);
      end
    end
  endtask

  task automatic test_count_up();
    do_reset();
    for (int i = 0; i < 12; i++) apply_tick(1'b1, 1'b0, $urandom_range(1, 3));
    vectors++;
    if (bcd !== 16'h0012) begin
      miscompares++;
      $display("FAIL count_up_12: bcd=%h, want 0012", bcd);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    apply_tick(1'b0, 1'b0, 1);
    vectors++;
    if (bcd !== 16'h9999) begin
      miscompares++;
      $display("FAIL wrap_down: bcd=%h, want 9999", bcd);
    end
    apply_tick(1'b1, 1'b0, 2);
    vectors++;
    if (bcd !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_up: bcd=%h, want 0000", bcd);
    end
    // Random dithering around the boundary, paused wraps must not pulse.
    for (int i = 0; i < 20; i++)
      apply_tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom_range(1, 2));
  endtask

  task automatic test_pause();
    int held;
    held = model;
    for (int i = 0; i < 3; i++) apply_tick(1'($urandom_range(0, 1)), 1'b1, $urandom_range(1, 3));
    vectors++;
    if (bcd !== to_bcd(held)) begin
      miscompares++;
      $display("FAIL pause_hold: bcd=%h, want %h", bcd, to_bcd(held));
    end
    // pause is high through the low phase and drops on the edge cycle.
    cnt_en = 1'b0;
    pause  = 1'b1;
    step();
    cnt_en = 1'b1;
    pause  = 1'b0;
    up_dn  = 1'b1;
    step();
    model = (model + 1) % 10000;
    vectors++;
    if (bcd !== to_bcd(model)) begin
      miscompares++;
      $display("FAIL pause_release_tick: bcd=%h, want %h", bcd, to_bcd(model));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      apply_tick(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), $urandom_range(1, 4));
  endtask

  task automatic test_scan();
    int        idx;
    bit        found;
    logic [3:0] prev_an;
    do_reset();
    for (int i = 0; i < 42; i++) apply_tick(1'b1, 1'b0, 1);
    vectors++;
    if (bcd !== 16'h0042) begin
      miscompares++;
      $display("FAIL scan_preload: bcd=%h, want 0042", bcd);
    end
    prev_an = an;
    found   = 1'b0;
    for (int i = 0; i < 4 * SCAN_DIV && !found; i++) begin
      step();
      if (an !== prev_an) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL scan_timeout: an stuck at %b", an);
    end
    case (an)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: idx = 0;
    endcase
    for (int slot = 0; slot < 16; slot++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        vectors++;
        if (an !== ~(4'b0001 << idx) || seg !== exp_seg(idx, model)) begin
          miscompares++;
          $display("FAIL scan_slot%0d_digit%0d: an=%b seg=%b, want an=%b seg=%b",
                   slot, idx, an, seg, ~(4'b0001 << idx), exp_seg(idx, model));
        end
        step();
      end
      idx = (idx + 1) % 4;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    for (int i = 0; i < 735; i++) apply_tick(1'b1, 1'b0, 1);
    vectors++;
    if (bcd !== 16'h0735) begin
      miscompares++;
      $display("FAIL mid_preload: bcd=%h, want 0735", bcd);
    end
    found = (an === 4'b1011);
    for (int i = 0; i < 8 * SCAN_DIV && !found; i++) begin
      step();
      if (an === 4'b1011) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_d2_timeout: an=%b, want 1011 seen", an);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model = 0;
    vectors++;
    if (bcd !== 16'h0000 || an !== 4'b1110 || wrap !== 1'b0 || seg !== 7'b1000000) begin
      miscompares++;
      $display("FAIL mid_reset: bcd=%h an=%b wrap=%b seg=%b, want 0000 1110 0 1000000",
               bcd, an, wrap, seg);
    end
    step();
    vectors++;
    if (an !== 4'b1110 || bcd !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset_scan_restart: an=%b bcd=%h, want 1110 0000", an, bcd);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    cnt_en = 1'b1;
    up_dn  = 1'b1;
    pause  = 1'b0;
    test_reset();
    test_count_up();
    test_wrap();
    test_pause();
    test_random();
    test_scan();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
